// File: rtl/seg_seq_decoder_pkg.sv
// Shared codes for the digit-sequence display FSM and its receive-side decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg_seq_decoder_pkg;

    // Tracker state encoding; the display side uses the same package.
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Active-low 7-segment codes, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Digit reported for a pattern outside the table.
    localparam logic [3:0] DIGIT_BAD = 4'hF;

endpackage

// File: rtl/seg_seq_decoder_seg7_decode.sv
// Purpose: exact-match active-low 7-segment pattern -> BCD digit decoder.
// Latency: combinational. Backpressure: none.
// Ports: seg (pattern in), vld (pattern is one of the ten codes), dig (digit, 4'hF when not vld).
module seg7_decode
    import seg_seq_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic       vld,
    output logic [3:0] dig
);

    always_comb begin
        vld = 1'b1;
        dig = DIGIT_BAD;
        case (seg)
            SEG_0:   dig = 4'd0;
            SEG_1:   dig = 4'd1;
            SEG_2:   dig = 4'd2;
            SEG_3:   dig = 4'd3;
            SEG_4:   dig = 4'd4;
            SEG_5:   dig = 4'd5;
            SEG_6:   dig = 4'd6;
            SEG_7:   dig = 4'd7;
            SEG_8:   dig = 4'd8;
            SEG_9:   dig = 4'd9;
            default: vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_seq_decoder.sv
// Purpose: decode a strobed 7-segment stream, lock onto the SEQ digit cycle, infer direction, count errors.
// Latency: 1 cycle from seg_valid to digit_valid/err/state outputs, all registered.
// Backpressure: none; accepts a strobe every cycle at full rate.
// Ports: clk, reset_n (async active-low); seg_valid/seg_in in; digit, digit_valid, locked, dir, pos, err, err_count out.
module seg_seq_decoder
    import seg_seq_decoder_pkg::*;
#(
    parameter int          N_DIGITS = 8,
    parameter logic [31:0] SEQ      = 32'h21278163
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       seg_valid,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       locked,
    output logic       dir,
    output logic [2:0] pos,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [2:0] LAST = 3'(N_DIGITS - 1);

    // Position 0 sits in the most significant used nibble of SEQ.
    function automatic logic [3:0] seq_at(input logic [2:0] p);
        logic [31:0] sh;
        sh = SEQ >> (4 * (N_DIGITS - 1 - int'(p)));
        return sh[3:0];
    endfunction

    state_t     state;
    logic       dec_vld;
    logic [3:0] dec_dig;
    logic [2:0] fwd_pos;
    logic [2:0] bwd_pos;
    logic [2:0] exp_pos;
    logic       hit_first;
    logic       hit_second;
    logic       hit_last;
    logic       hit_exp;

    seg7_decode u_dec (
        .seg (seg_in),
        .vld (dec_vld),
        .dig (dec_dig)
    );

    always_comb begin
        fwd_pos    = (pos == LAST) ? 3'd0 : pos + 3'd1;
        bwd_pos    = (pos == 3'd0) ? LAST : pos - 3'd1;
        exp_pos    = dir ? fwd_pos : bwd_pos;
        // An undecodable pattern never matches, even if SEQ held an 'F' nibble.
        hit_first  = dec_vld && (dec_dig == seq_at(3'd0));
        hit_second = dec_vld && (dec_dig == seq_at(3'd1));
        hit_last   = dec_vld && (dec_dig == seq_at(LAST));
        hit_exp    = dec_vld && (dec_dig == seq_at(exp_pos));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HUNT;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            locked      <= 1'b0;
            dir         <= 1'b0;
            pos         <= 3'd0;
            err         <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            digit_valid <= seg_valid;
            err         <= 1'b0;
            if (seg_valid) begin
                digit <= dec_dig;
                case (state)
                    HUNT: begin
                        if (hit_first) begin
                            pos   <= 3'd0;
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        // Forward is checked first so it wins when both neighbours match.
                        if (hit_second) begin
                            dir    <= 1'b1;
                            pos    <= 3'd1;
                            locked <= 1'b1;
                            state  <= LOCK;
                        end else if (hit_last) begin
                            dir    <= 1'b0;
                            pos    <= LAST;
                            locked <= 1'b1;
                            state  <= LOCK;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LOCK: begin
                        if (hit_exp) begin
                            pos <= exp_pos;
                        end else begin
                            err    <= 1'b1;
                            locked <= 1'b0;
                            state  <= HUNT;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end
                    end
                    default: begin
                        locked <= 1'b0;
                        state  <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule
